// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//
// Assembles the byte stream coming out of a UART receiver into framed packets
//   SYNC, LEN, PAYLOAD[LEN], CHK
// where CHK is the 8-bit XOR of LEN and every payload byte. A good frame is
// kept in an internal payload buffer and announced to the host with a level
// frame_valid that stays high until frame_ack. Malformed frames are rejected
// with one-cycle error pulses.
//
// Optional feature macro: UART_FRAME_TIMEOUT_EN
//   When defined, an inter-byte timeout aborts a stalled partial frame and
//   reports it on the extra err_timeout pulse output.
//
// Parameters
//   MAX_LEN       maximum payload bytes and buffer depth (1..255)
//   SYNC_BYTE     frame start marker
//   TIMEOUT_CLKS  inter-byte timeout in clk cycles (timeout build only)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   byte_recv    received byte from the UART receiver
//   recv_valid   one byte accepted on each cycle this is high
//   frame_valid  good frame held in the buffer; held until frame_ack
//   frame_len    payload length of the held frame
//   frame_ack    host releases the held frame
//   rd_addr      payload buffer read address
//   rd_data      payload byte at rd_addr (combinational, 0 beyond MAX_LEN)
//   err_len      pulse: LEN byte was 0 or larger than MAX_LEN
//   err_chk      pulse: checksum mismatch
//   err_drop     pulse: byte arrived while a frame was held
//   err_timeout  pulse: partial frame abandoned (timeout build only)
// -----------------------------------------------------------------------------
module uart_frame_parser #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1740,
    // A one-entry buffer still needs a one-bit address port.
    localparam int        AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    byte_recv,
    input  logic          recv_valid,
    output logic          frame_valid,
    output logic [7:0]    frame_len,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_len,
    output logic          err_chk,
`ifdef UART_FRAME_TIMEOUT_EN
    output logic          err_timeout,
`endif
    output logic          err_drop
);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_HOLD    = 3'd4
    } state_e;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     r_state;
    logic [7:0] r_len;
    logic [7:0] r_idx;
    logic [7:0] r_chk;
    logic [7:0] r_frame_len;
    logic       r_frame_valid;
    logic       r_err_len;
    logic       r_err_chk;
    logic       r_err_drop;
    logic [7:0] r_buf [MAX_LEN];

    state_e     w_state_nxt;
    logic [7:0] w_len_nxt;
    logic [7:0] w_idx_nxt;
    logic [7:0] w_chk_nxt;
    logic [7:0] w_frame_len_nxt;
    logic       w_frame_valid_nxt;
    logic       w_err_len_nxt;
    logic       w_err_chk_nxt;
    logic       w_err_drop_nxt;
    logic       w_buf_we;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int          TW       = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err_timeout;
    logic [TW-1:0] w_tmo_cnt_nxt;
    logic          w_err_timeout_nxt;
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt       = r_state;
        w_len_nxt         = r_len;
        w_idx_nxt         = r_idx;
        w_chk_nxt         = r_chk;
        w_frame_len_nxt   = r_frame_len;
        w_frame_valid_nxt = r_frame_valid;
        w_err_len_nxt     = 1'b0;
        w_err_chk_nxt     = 1'b0;
        w_err_drop_nxt    = 1'b0;
        w_buf_we          = 1'b0;

        case (r_state)
            S_HUNT: begin
                if (recv_valid && byte_recv == SYNC_BYTE) begin
                    w_state_nxt = S_LEN;
                end
            end

            S_LEN: begin
                if (recv_valid) begin
                    if (byte_recv == 8'd0 || byte_recv > MAX_LEN_B) begin
                        w_err_len_nxt = 1'b1;
                        w_state_nxt   = S_HUNT;
                    end else begin
                        w_len_nxt   = byte_recv;
                        w_chk_nxt   = byte_recv;
                        w_idx_nxt   = 8'd0;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                if (recv_valid) begin
                    w_buf_we  = 1'b1;
                    w_chk_nxt = r_chk ^ byte_recv;
                    // idx returns to 0 only when the payload is complete, so a
                    // MAX_LEN frame never indexes past the buffer.
                    if (r_idx == r_len - 8'd1) begin
                        w_idx_nxt   = 8'd0;
                        w_state_nxt = S_CHK;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end
            end

            S_CHK: begin
                if (recv_valid) begin
                    if (byte_recv == r_chk) begin
                        w_frame_len_nxt   = r_len;
                        w_frame_valid_nxt = 1'b1;
                        w_state_nxt       = S_HOLD;
                    end else begin
                        // A rejected CHK byte is consumed here; it is not
                        // offered to HUNT as a possible SYNC.
                        w_err_chk_nxt = 1'b1;
                        w_state_nxt   = S_HUNT;
                    end
                end
            end

            S_HOLD: begin
                // The buffer is busy, including on the ack cycle itself.
                if (recv_valid) begin
                    w_err_drop_nxt = 1'b1;
                end
                if (frame_ack) begin
                    w_frame_valid_nxt = 1'b0;
                    w_state_nxt       = S_HUNT;
                end
            end

            default: begin
                w_frame_valid_nxt = 1'b0;
                w_state_nxt       = S_HUNT;
            end
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        w_tmo_cnt_nxt     = '0;
        w_err_timeout_nxt = 1'b0;
        if (r_state == S_LEN || r_state == S_PAYLOAD || r_state == S_CHK) begin
            // An arriving byte always beats expiry on the same cycle.
            if (recv_valid) begin
                w_tmo_cnt_nxt = '0;
            end else if (r_tmo_cnt == TMO_LAST) begin
                w_err_timeout_nxt = 1'b1;
                w_idx_nxt         = 8'd0;
                w_state_nxt       = S_HUNT;
            end else begin
                w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
            end
        end
`endif
    end

    // -------------------------------------------------------------------------
    // State and control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_HUNT;
            r_len         <= 8'd0;
            r_idx         <= 8'd0;
            r_chk         <= 8'd0;
            r_frame_len   <= 8'd0;
            r_frame_valid <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_drop    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_idx         <= w_idx_nxt;
            r_chk         <= w_chk_nxt;
            r_frame_len   <= w_frame_len_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_err_len     <= w_err_len_nxt;
            r_err_chk     <= w_err_chk_nxt;
            r_err_drop    <= w_err_drop_nxt;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    assign err_timeout = r_err_timeout;
`endif

    // -------------------------------------------------------------------------
    // Payload buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer has no reset; its contents are only meaningful behind
    // frame_valid, which is reset, so resetting storage would buy nothing.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_idx[AW-1:0]] <= byte_recv;
        end
    end

    // Addresses beyond the buffer only exist when MAX_LEN is not a power of 2.
    generate
        if (MAX_LEN == (1 << AW)) begin : g_rd_full
            assign rd_data = r_buf[rd_addr];
        end else begin : g_rd_guard
            assign rd_data = (int'(rd_addr) < MAX_LEN) ? r_buf[rd_addr] : 8'h00;
        end
    endgenerate

    assign frame_valid = r_frame_valid;
    assign frame_len   = r_frame_len;
    assign err_len     = r_err_len;
    assign err_chk     = r_err_chk;
    assign err_drop    = r_err_drop;

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
//
// Scoreboard bench for uart_frame_parser. Stimulus builds whole frames (good,
// bad length, bad checksum, noise, drops while held) and pushes the outcome
// each one must produce. A monitor pops an expectation for every error pulse
// and every frame_valid rise; a reader walks the held payload through rd_addr.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_frame_parser;

    localparam int         TB_MAX  = 16;
    localparam int         TB_AW   = $clog2(TB_MAX);
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TB_TMO  = 1740;

    typedef enum logic [2:0] {EV_FRAME, EV_LEN, EV_CHK, EV_DROP, EV_TMO} ev_e;
    typedef struct packed {
        ev_e        kind;
        logic [7:0] len;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       byte_recv;
    logic             recv_valid;
    logic             frame_valid;
    logic [7:0]       frame_len;
    logic             frame_ack;
    logic [TB_AW-1:0] rd_addr;
    logic [7:0]       rd_data;
    logic             err_len;
    logic             err_chk;
    logic             err_drop;
`ifdef UART_FRAME_TIMEOUT_EN
    logic             err_timeout;
`endif

    uart_frame_parser #(
        .MAX_LEN      (TB_MAX),
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_CLKS (TB_TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_recv   (byte_recv),
        .recv_valid  (recv_valid),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_len     (err_len),
        .err_chk     (err_chk),
`ifdef UART_FRAME_TIMEOUT_EN
        .err_timeout (err_timeout),
`endif
        .err_drop    (err_drop)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       exp_q [$];
    logic [7:0] payload_q [$];
    logic [7:0] rd_len_q [$];
    int         rd_done = 0;
    int         rd_target = 0;
    logic [7:0] cur_pl [TB_MAX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    task automatic expect_event(input ev_e k, input logic [7:0] l);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", k, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (e.kind == EV_FRAME) begin
                if (k == EV_FRAME) check("frame_len", 32'(l), 32'(e.len));
                rd_len_q.push_back(e.len);
            end
        end
    endtask

    initial begin : monitor
        logic prev_fv;
        int   n_pulse;
        prev_fv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_fv = 1'b0;
            end else begin
                n_pulse = int'(err_len) + int'(err_chk) + int'(err_drop);
`ifdef UART_FRAME_TIMEOUT_EN
                n_pulse += int'(err_timeout);
`endif
                if (n_pulse > 1) check("pulse_exclusive", 32'(n_pulse), 32'd1);
                if (err_len)  expect_event(EV_LEN, 8'd0);
                if (err_chk)  expect_event(EV_CHK, 8'd0);
                if (err_drop) expect_event(EV_DROP, 8'd0);
`ifdef UART_FRAME_TIMEOUT_EN
                if (err_timeout) expect_event(EV_TMO, 8'd0);
`endif
                if (frame_valid && !prev_fv) expect_event(EV_FRAME, frame_len);
                prev_fv = frame_valid;
            end
        end
    end

    // Walks a held frame one byte per cycle and compares against the payload
    // the stimulus queued for it.
    initial begin : reader
        logic [7:0] l;
        logic [7:0] b;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (rd_len_q.size() != 0) begin
                l = rd_len_q.pop_front();
                for (int i = 0; i < int'(l); i++) begin
                    if (i > 0) @(negedge clk);
                    rd_addr = TB_AW'(i);
                    #1;
                    b = (payload_q.size() != 0) ? payload_q.pop_front() : 8'h00;
                    check("rd_data", 32'(rd_data), 32'(b));
                    check("held_valid", 32'(frame_valid), 32'd1);
                end
                rd_done++;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_recv  = b;
        recv_valid = 1'b1;
        @(posedge clk);
        #1;
        recv_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_not_sync();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == SYNC);
        return b;
    endfunction

    // Sends SYNC, LEN, cur_pl[0..len-1], CHK. The checksum is the XOR of the
    // length and payload; a non-zero mask turns it into a bad frame.
    task automatic send_frame(input int len, input logic [7:0] mask, input bit gaps);
        logic [7:0] chk;
        chk = 8'(len);
        for (int i = 0; i < len; i++) chk ^= cur_pl[i];
        if (mask == 8'h00) begin
            exp_q.push_back('{kind: EV_FRAME, len: 8'(len)});
            for (int i = 0; i < len; i++) payload_q.push_back(cur_pl[i]);
            rd_target++;
        end else begin
            exp_q.push_back('{kind: EV_CHK, len: 8'd0});
        end
        send_byte(SYNC);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            if (gaps) tick($urandom_range(0, 2));
            send_byte(cur_pl[i]);
        end
        send_byte(chk ^ mask);
        if (mask == 8'h00) check("frame_latency", 32'(frame_valid), 32'd1);
        else               check("err_chk_latency", 32'(err_chk), 32'd1);
    endtask

    task automatic rand_payload(input int len);
        for (int i = 0; i < len; i++) cur_pl[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic send_bad_len(input logic [7:0] l);
        exp_q.push_back('{kind: EV_LEN, len: 8'd0});
        send_byte(SYNC);
        send_byte(l);
        check("err_len_latency", 32'(err_len), 32'd1);
    endtask

    task automatic send_drop(input logic [7:0] b);
        exp_q.push_back('{kind: EV_DROP, len: 8'd0});
        send_byte(b);
        check("err_drop_latency", 32'(err_drop), 32'd1);
    endtask

    // Waits for the reader to finish the held frame, then acknowledges it,
    // optionally with a byte arriving on the ack cycle.
    task automatic release_frame(input bit with_byte);
        int n = 0;
        while (rd_done < rd_target && n < 400) begin
            tick(1);
            n++;
        end
        check("read_done", 32'(rd_done >= rd_target), 32'd1);
        frame_ack = 1'b1;
        if (with_byte) begin
            exp_q.push_back('{kind: EV_DROP, len: 8'd0});
            byte_recv  = 8'($urandom_range(0, 255));
            recv_valid = 1'b1;
        end
        tick(1);
        frame_ack  = 1'b0;
        recv_valid = 1'b0;
        check("ack_clears_valid", 32'(frame_valid), 32'd0);
        if (with_byte) check("ack_cycle_drop", 32'(err_drop), 32'd1);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int len;
        rst_n      = 1'b0;
        byte_recv  = 8'h00;
        recv_valid = 1'b0;
        frame_ack  = 1'b0;
        tick(3);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_len",   32'(frame_len),   32'd0);
        check("rst_err_pulses",  32'({err_len, err_chk, err_drop}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // A5 03 11 22 33 03: good frame, then ack.
        cur_pl[0] = 8'h11; cur_pl[1] = 8'h22; cur_pl[2] = 8'h33;
        send_frame(3, 8'h00, 1'b0);
        check("tp1_len", 32'(frame_len), 32'd3);
        release_frame(1'b0);

        // A5 03 11 22 33 04: bad checksum, then A5 01 7E 7F.
        send_frame(3, 8'h07, 1'b0);
        check("tp2_no_valid", 32'(frame_valid), 32'd0);
        cur_pl[0] = 8'h7E;
        send_frame(1, 8'h00, 1'b0);
        release_frame(1'b0);

        // A rejected CHK byte equal to SYNC must not start a frame; a 00
        // following it would otherwise raise err_len.
        cur_pl[0] = 8'h11; cur_pl[1] = 8'h22; cur_pl[2] = 8'h33;
        send_frame(3, 8'hA6, 1'b0);
        send_byte(8'h00);
        tick(2);

        // A5 00 and A5 11 with MAX_LEN=16, then a good frame.
        send_bad_len(8'h00);
        send_bad_len(8'h11);
        rand_payload(2);
        send_frame(2, 8'h00, 1'b0);
        release_frame(1'b0);

        // Held frame, bytes 55 66 dropped, contents unchanged, ack with byte.
        rand_payload(TB_MAX);
        send_frame(TB_MAX, 8'h00, 1'b0);
        send_drop(8'h55);
        send_drop(8'h66);
        check("drop_len_kept", 32'(frame_len), 32'(TB_MAX));
        release_frame(1'b1);
        rand_payload(4);
        send_frame(4, 8'h00, 1'b1);
        release_frame(1'b0);

        // Reset mid-frame after A5 02 11.
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({frame_valid, frame_len, err_len, err_chk, err_drop}), 32'd0);
        tick(1);
        rst_n = 1'b1;
        send_byte(8'h22);
        send_byte(8'h13);
        tick(3);
        rand_payload(2);
        send_frame(2, 8'h00, 1'b0);
        release_frame(1'b0);

`ifdef UART_FRAME_TIMEOUT_EN
        // Idle for the full timeout after A5 02 11.
        exp_q.push_back('{kind: EV_TMO, len: 8'd0});
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        tick(TB_TMO);
        check("timeout_latency", 32'(err_timeout), 32'd1);
        tick(2);
        // Next byte lands exactly on the expiry cycle: the frame continues.
        cur_pl[0] = 8'h11; cur_pl[1] = 8'h22;
        exp_q.push_back('{kind: EV_FRAME, len: 8'd2});
        payload_q.push_back(8'h11);
        payload_q.push_back(8'h22);
        rd_target++;
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        tick(TB_TMO - 1);
        send_byte(8'h22);
        send_byte(8'h02 ^ 8'h11 ^ 8'h22);
        check("timeout_race_frame", 32'(frame_valid), 32'd1);
        release_frame(1'b0);
`endif

        // Randomized mix of frame types.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++) send_byte(rand_not_sync());
                end
                1, 2: begin
                    len = ($urandom_range(0, 3) == 0) ? TB_MAX : int'($urandom_range(1, TB_MAX));
                    rand_payload(len);
                    send_frame(len, 8'h00, 1'b1);
                    release_frame(1'($urandom_range(0, 1)));
                end
                3: begin
                    len = int'($urandom_range(1, TB_MAX));
                    rand_payload(len);
                    send_frame(len, 8'($urandom_range(1, 255)), 1'b1);
                end
                4: begin
                    if ($urandom_range(0, 1) == 0) send_bad_len(8'h00);
                    else send_bad_len(8'($urandom_range(TB_MAX + 1, 255)));
                end
                default: begin
                    len = int'($urandom_range(1, TB_MAX));
                    rand_payload(len);
                    send_frame(len, 8'h00, 1'b1);
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                        send_drop(8'($urandom_range(0, 255)));
                    check("rand_drop_len_kept", 32'(frame_len), 32'(len));
                    release_frame(1'b0);
                end
            endcase
            tick($urandom_range(0, 3));
        end

        tick(20);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("payload_consumed", 32'(payload_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
